countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 181 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// mm:ss.cc BCD countdown timer clocked at 100 Hz with load/start/pause control.
// Optional alarm hold logic is enabled by defining COUNTDOWN_ALARM_EN.
module countdown_timer #(
  parameter int ALARM_CYCLES = 200
) (
  input  logic       clk100hz,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_o,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_o,
  input  logic       start_stop,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Returns {borrow_out, digit} for one BCD digit given a borrow request.
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic b, input logic [3:0] wrap);
    if (!b) begin
      dec_digit = {1'b0, d};
    end else if (d == 4'd0) begin
      dec_digit = {1'b1, wrap};
    end else begin
      dec_digit = {1'b0, d - 4'd1};
    end
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
    clamp = (d > max) ? max : d;
  endfunction

  logic [1:0] state_r, state_s;
  logic [3:0] min_t_s, min_o_s, sec_t_s, sec_o_s, cs_t_s, cs_o_s;
  logic [3:0] min_t_d, min_o_d, sec_t_d, sec_o_d, cs_t_d, cs_o_d;
  logic       b1_s, b2_s, b3_s, b4_s, b5_s, unused_borrow_s;
  logic       is_zero_s, dec_zero_s, take_load_s, take_dec_s, done_s;

  always_comb begin
    {b1_s, cs_o_d}           = dec_digit(cs_o, 1'b1, 4'd9);
    {b2_s, cs_t_d}           = dec_digit(cs_t, b1_s, 4'd9);
    {b3_s, sec_o_d}          = dec_digit(sec_o, b2_s, 4'd9);
    {b4_s, sec_t_d}          = dec_digit(sec_t, b3_s, 4'd5);
    {b5_s, min_o_d}          = dec_digit(min_o, b4_s, 4'd9);
    {unused_borrow_s, min_t_d} = dec_digit(min_t, b5_s, 4'd9);
    is_zero_s  = ({min_t, min_o, sec_t, sec_o, cs_t, cs_o} == 24'd0);
    dec_zero_s = ({min_t_d, min_o_d, sec_t_d, sec_o_d, cs_t_d, cs_o_d} == 24'd0);

    state_s     = state_r;
    take_load_s = 1'b0;
    take_dec_s  = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (load) begin
          take_load_s = 1'b1;
        end else if (start_stop && !is_zero_s) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (start_stop) begin
          state_s = S_PAUSE;
        end else begin
          take_dec_s = 1'b1;
          if (dec_zero_s) begin
            state_s = S_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (load) begin
          take_load_s = 1'b1;
        end else if (start_stop) begin
          state_s = S_RUN;
        end else begin
          state_s = S_PAUSE;
        end
      end
      S_DONE: begin
        if (load) begin
          take_load_s = 1'b1;
        end else if (start_stop) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (take_load_s) begin
      state_s = S_IDLE;
      min_t_s = clamp(ld_min_t, 4'd9);
      min_o_s = clamp(ld_min_o, 4'd9);
      sec_t_s = clamp(ld_sec_t, 4'd5);
      sec_o_s = clamp(ld_sec_o, 4'd9);
      cs_t_s  = 4'd0;
      cs_o_s  = 4'd0;
    end else if (take_dec_s) begin
      {min_t_s, min_o_s, sec_t_s, sec_o_s, cs_t_s, cs_o_s} =
        {min_t_d, min_o_d, sec_t_d, sec_o_d, cs_t_d, cs_o_d};
    end else begin
      {min_t_s, min_o_s, sec_t_s, sec_o_s, cs_t_s, cs_o_s} =
        {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
    end
  end

  always_ff @(posedge clk100hz) begin
    if (rst) begin
      state_r <= S_IDLE;
      {min_t, min_o, sec_t, sec_o, cs_t, cs_o} <= 24'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      {min_t, min_o, sec_t, sec_o, cs_t, cs_o} <= {min_t_s, min_o_s, sec_t_s, sec_o_s, cs_t_s, cs_o_s};
      running <= (state_s == S_RUN);
      done    <= done_s;
    end
  end

`ifdef COUNTDOWN_ALARM_EN
  logic [9:0] alarm_cnt_r, alarm_cnt_s;
  logic       alarm_s;

  // Alarm starts on DONE entry, is cleared by any accepted command in DONE, else counts down.
  always_comb begin
    if (done_s) begin
      alarm_s     = 1'b1;
      alarm_cnt_s = 10'(ALARM_CYCLES);
    end else if ((state_r == S_DONE) && (load || start_stop)) begin
      alarm_s     = 1'b0;
      alarm_cnt_s = 10'd0;
    end else if (alarm && (alarm_cnt_r <= 10'd1)) begin
      alarm_s     = 1'b0;
      alarm_cnt_s = 10'd0;
    end else if (alarm) begin
      alarm_s     = 1'b1;
      alarm_cnt_s = alarm_cnt_r - 10'd1;
    end else begin
      alarm_s     = 1'b0;
      alarm_cnt_s = alarm_cnt_r;
    end
  end

  always_ff @(posedge clk100hz) begin
    if (rst) begin
      alarm       <= 1'b0;
      alarm_cnt_r <= 10'd0;
    end else begin
      alarm       <= alarm_s;
      alarm_cnt_r <= alarm_cnt_s;
    end
  end
`else
  logic unused_alarm_cfg;
  assign unused_alarm_cfg = (ALARM_CYCLES == 0);
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (alarm checks depend on COUNTDOWN_ALARM_EN).
module tb_countdown_timer;

  logic       clk100hz;
  logic       rst, load, start_stop;
  logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;
  logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;
  logic       running, done, alarm;
  logic [23:0] value;
  int checks = 0;
  int errors = 0;
  int n;

  assign value = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};

  countdown_timer #(.ALARM_CYCLES(200)) dut (
    .clk100hz(clk100hz), .rst(rst), .load(load),
    .ld_min_t(ld_min_t), .ld_min_o(ld_min_o), .ld_sec_t(ld_sec_t), .ld_sec_o(ld_sec_o),
    .start_stop(start_stop),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o), .cs_t(cs_t), .cs_o(cs_o),
    .running(running), .done(done), .alarm(alarm)
  );

  initial clk100hz = 1'b0;
  always #5 clk100hz = ~clk100hz;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100hz);
    #1;
  endtask

  task automatic ticks(input int cnt);
    repeat (cnt) tick();
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    tick();
    start_stop = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] mt, input logic [3:0] mo, input logic [3:0] st,
                         input logic [3:0] so, input logic ss);
    ld_min_t = mt; ld_min_o = mo; ld_sec_t = st; ld_sec_o = so;
    load = 1'b1;
    start_stop = ss;
    tick();
    load = 1'b0;
    start_stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; start_stop = 1'b0;
    ld_min_t = 4'd0; ld_min_o = 4'd0; ld_sec_t = 4'd0; ld_sec_o = 4'd0;
    ticks(2);
    rst = 1'b0;
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_running", 32'(running), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_alarm", 32'(alarm), 32'h0);

    // start at zero is ignored
    pulse_ss();
    check_eq("zero_start_running", 32'(running), 32'h0);
    check_eq("zero_start_value", 32'(value), 32'h0);

    // one second countdown to DONE
    do_load(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    check_eq("load_0001", 32'(value), 32'h000100);
    pulse_ss();
    check_eq("start_running", 32'(running), 32'h1);
    check_eq("start_no_dec", 32'(value), 32'h000100);
    ticks(99);
    check_eq("pre_zero_value", 32'(value), 32'h000001);
    check_eq("pre_zero_done", 32'(done), 32'h0);
    tick();
    check_eq("zero_value", 32'(value), 32'h0);
    check_eq("zero_done", 32'(done), 32'h1);
    check_eq("zero_running", 32'(running), 32'h0);
`ifdef COUNTDOWN_ALARM_EN
    check_eq("alarm_rise", 32'(alarm), 32'h1);
`else
    check_eq("alarm_off_entry", 32'(alarm), 32'h0);
`endif
    tick();
    check_eq("done_one_cycle", 32'(done), 32'h0);
    check_eq("done_hold_value", 32'(value), 32'h0);
`ifdef COUNTDOWN_ALARM_EN
    n = 1;
    while (alarm === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    check_eq("alarm_len", 32'(n), 32'd200);
`else
    ticks(5);
    check_eq("alarm_off_hold", 32'(alarm), 32'h0);
`endif
    pulse_ss();
    check_eq("ack_running", 32'(running), 32'h0);

    // clamping
    do_load(4'd1, 4'd12, 4'd8, 4'd15, 1'b0);
    check_eq("clamp_all", 32'(value), 32'h195900);
    do_load(4'd0, 4'd0, 4'd7, 4'd1, 1'b0);
    check_eq("clamp_sec_t", 32'(value), 32'h005100);

    // digit wrap and load ignored in RUN
    do_load(4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    check_eq("load_1000", 32'(value), 32'h100000);
    pulse_ss();
    tick();
    check_eq("wrap", 32'(value), 32'h095999);
    do_load(4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
    check_eq("load_in_run_ignored", 32'(value), 32'h095998);
    check_eq("load_in_run_running", 32'(running), 32'h1);
    pulse_ss();
    check_eq("pause_hold", 32'(value), 32'h095998);
    check_eq("pause_running", 32'(running), 32'h0);

    // pause / resume from 04.63
    do_load(4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    check_eq("load_in_pause", 32'(value), 32'h000500);
    pulse_ss();
    ticks(37);
    check_eq("run37", 32'(value), 32'h000463);
    pulse_ss();
    check_eq("pause2_running", 32'(running), 32'h0);
    ticks(50);
    check_eq("pause2_hold", 32'(value), 32'h000463);
    pulse_ss();
    check_eq("resume_running", 32'(running), 32'h1);
    check_eq("resume_value", 32'(value), 32'h000463);
    tick();
    check_eq("resume_dec", 32'(value), 32'h000462);

    // load + start_stop together in PAUSE: load wins, IDLE
    pulse_ss();
    do_load(4'd0, 4'd0, 4'd3, 4'd0, 1'b1);
    check_eq("load_ss_value", 32'(value), 32'h003000);
    check_eq("load_ss_running", 32'(running), 32'h0);
    pulse_ss();
    check_eq("idle_after_load_ss", 32'(running), 32'h1);

    // reset mid-run at 00:30.12
    pulse_ss();
    do_load(4'd0, 4'd0, 4'd3, 4'd1, 1'b0);
    pulse_ss();
    ticks(88);
    check_eq("pre_rst_value", 32'(value), 32'h003012);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrun_rst_value", 32'(value), 32'h0);
    check_eq("midrun_rst_running", 32'(running), 32'h0);
    check_eq("midrun_rst_done", 32'(done), 32'h0);
    check_eq("midrun_rst_alarm", 32'(alarm), 32'h0);

`ifdef COUNTDOWN_ALARM_EN
    // acknowledge at alarm cycle 50
    do_load(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    pulse_ss();
    ticks(100);
    check_eq("ack_entry_alarm", 32'(alarm), 32'h1);
    ticks(49);
    check_eq("ack_c50_alarm", 32'(alarm), 32'h1);
    pulse_ss();
    check_eq("ack_clears_alarm", 32'(alarm), 32'h0);
    check_eq("ack_running", 32'(running), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
